// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit state type and frame constants
package uart_pkg;

   // Transmitter sequence: fetch a byte from the FIFO, then start, data, stop bits.
   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam int   UART_FRAME_BITS = 10;   // start + 8 data + stop
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Clock cycles occupied by one complete frame on the line.
   function automatic int uart_frame_clks(input int clks_per_bit);
      return UART_FRAME_BITS * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter with clear and end-of-bit tick
//
// Purpose: counts 0..CLKS_PER_BIT-1 while enabled, wrapping to 0 on every
// bit boundary; o_bit_end marks the last cycle of the current bit period.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset
//   i_clear    forces the count back to 0 (start of a new frame)
//   i_enable   advances the count
//   o_bit_end  high during the final cycle of a bit period
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_bit_end
);

   localparam int               CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == LAST);
   assign o_bit_end = i_enable && w_at_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_at_last ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the transmit FIFO into 8N1 UART frames
//
// Purpose: reads one byte per frame from a normal-mode FIFO and shifts it out
// LSB-first with one start and one stop bit, CLKS_PER_BIT clocks per bit.
// Ports:
//   Mclk        rising-edge clock
//   Reset       asynchronous active-high reset (line returns high at once)
//   fifo_empty  FIFO empty flag, sampled only in IDLE
//   fifo_q      FIFO read data, valid the edge after the read strobe
//   tx_enable   gates the start of new frames; a running frame completes
//   fifo_rdreq  one-cycle FIFO read strobe
//   tx          serial line, idle high
//   busy        high whenever the transmitter is not idle
//   tx_done     one-cycle pulse after the stop bit
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       Mclk,
   input  logic       Reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_q,
   input  logic       tx_enable,
   output logic       fifo_rdreq,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   uart_state_t r_state, w_state_nx;
   logic [7:0]  r_shift, w_shift_nx;
   logic [2:0]  r_bit_idx, w_bit_idx_nx;
   logic        r_tx, w_tx_nx;
   logic        r_rdreq, w_rdreq_nx;
   logic        r_busy, w_busy_nx;
   logic        r_done, w_done_nx;
   logic        w_baud_clear;
   logic        w_baud_en;
   logic        w_bit_end;

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (Mclk),
      .i_rst     (Reset),
      .i_clear   (w_baud_clear),
      .i_enable  (w_baud_en),
      .o_bit_end (w_bit_end)
   );

   always_ff @(posedge Mclk or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= UART_IDLE_LEVEL;
         r_rdreq   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_shift   <= w_shift_nx;
         r_bit_idx <= w_bit_idx_nx;
         r_tx      <= w_tx_nx;
         r_rdreq   <= w_rdreq_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_shift_nx   = r_shift;
      w_bit_idx_nx = r_bit_idx;
      w_tx_nx      = r_tx;
      w_rdreq_nx   = 1'b0;
      w_busy_nx    = r_busy;
      w_done_nx    = 1'b0;
      w_baud_clear = 1'b0;
      w_baud_en    = 1'b0;

      case (r_state)
         IDLE: begin
            w_tx_nx      = UART_IDLE_LEVEL;
            w_baud_clear = 1'b1;
            if (tx_enable && !fifo_empty) begin
               w_rdreq_nx = 1'b1;
               w_busy_nx  = 1'b1;
               w_state_nx = READ;
            end
         end
         READ: begin
            // Normal-mode FIFO: data appears one edge after the strobe.
            w_baud_clear = 1'b1;
            w_state_nx   = LOAD;
         end
         LOAD: begin
            w_shift_nx   = fifo_q;
            w_tx_nx      = 1'b0;
            w_bit_idx_nx = '0;
            w_baud_clear = 1'b1;
            w_state_nx   = START;
         end
         START: begin
            w_baud_en = 1'b1;
            if (w_bit_end) begin
               w_tx_nx      = r_shift[0];
               w_bit_idx_nx = '0;
               w_state_nx   = DATA;
            end
         end
         DATA: begin
            w_baud_en = 1'b1;
            if (w_bit_end) begin
               if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                  w_tx_nx    = UART_IDLE_LEVEL;
                  w_state_nx = STOP;
               end else begin
                  // r_shift[0] is on the line now; [1] is the next bit.
                  w_tx_nx      = r_shift[1];
                  w_shift_nx   = r_shift >> 1;
                  w_bit_idx_nx = r_bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            w_baud_en = 1'b1;
            if (w_bit_end) begin
               w_done_nx  = 1'b1;
               w_busy_nx  = 1'b0;
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   assign fifo_rdreq = r_rdreq;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign tx_done    = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

   localparam int CPB0 = 4;
   localparam int CPB1 = 2;

   typedef struct {
      logic [7:0] data;
      bit         start_ok;
      bit         stop_ok;
      bit         uniform;
      bit         done_ok;
      bit         busy_ok;
      int         gap;
   } frame_t;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] empty = 2'b11;
   logic [1:0] en = 2'b11;
   logic [7:0] q [2];
   logic [1:0] rdreq, tx, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] fdat [2][$];
   frame_t     frm  [2][$];
   int         rd_cnt [2];
   int         underflow [2];
   int         done_cnt [2];

   int         cyc [2];
   bit         m_act [2];
   int         m_off [2];
   int         m_start [2];
   int         prev_stop [2];
   logic [9:0] m_lvl [2];
   bit         m_uni [2];
   bit         m_done [2];
   bit         m_busy [2];

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB0)) dut0 (
      .Mclk(clk), .Reset(rst[0]), .fifo_empty(empty[0]), .fifo_q(q[0]),
      .tx_enable(en[0]), .fifo_rdreq(rdreq[0]), .tx(tx[0]), .busy(busy[0]),
      .tx_done(done[0])
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB1)) dut1 (
      .Mclk(clk), .Reset(rst[1]), .fifo_empty(empty[1]), .fifo_q(q[1]),
      .tx_enable(en[1]), .fifo_rdreq(rdreq[1]), .tx(tx[1]), .busy(busy[1]),
      .tx_done(done[1])
   );

   initial begin
      for (int d = 0; d < 2; d++) begin
         rd_cnt[d] = 0; underflow[d] = 0; done_cnt[d] = 0; cyc[d] = 0;
         m_act[d] = 0; m_off[d] = 0; m_start[d] = 0; prev_stop[d] = -100000;
         q[d] = 8'h00;
      end
   end

   // Normal-mode FIFO: a strobe sampled on an edge pops the head onto q.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rdreq[d] === 1'b1) begin
            rd_cnt[d]++;
            if (fdat[d].size() == 0) underflow[d]++;
            else q[d] <= fdat[d].pop_front();
         end
         empty[d] <= (fdat[d].size() == 0);
      end
   end

   // Line receiver: from each falling edge, record the level at the start of
   // every bit window, note whether each window stays constant, and look at
   // busy/tx_done across the frame and on the cycle right after it.
   frame_t mf;
   int     mn;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mn = (d == 0) ? CPB0 : CPB1;
         cyc[d]++;
         if (done[d] === 1'b1) done_cnt[d]++;
         if (rst[d] !== 1'b0) begin
            m_act[d] = 0;
         end else begin
            if (!m_act[d] && tx[d] === 1'b0) begin
               m_act[d] = 1; m_off[d] = 0; m_start[d] = cyc[d];
               m_uni[d] = 1; m_done[d] = 1; m_busy[d] = 1; m_lvl[d] = '0;
            end
            if (m_act[d]) begin
               if (m_off[d] < 10 * mn) begin
                  if (m_off[d] % mn == 0) m_lvl[d][m_off[d] / mn] = tx[d];
                  else if (tx[d] !== m_lvl[d][m_off[d] / mn]) m_uni[d] = 0;
                  if (done[d] !== 1'b0) m_done[d] = 0;
                  if (busy[d] !== 1'b1) m_busy[d] = 0;
                  m_off[d]++;
               end else begin
                  mf.data     = m_lvl[d][8:1];
                  mf.start_ok = (m_lvl[d][0] === 1'b0);
                  mf.stop_ok  = (m_lvl[d][9] === 1'b1);
                  mf.uniform  = m_uni[d];
                  mf.done_ok  = m_done[d] && (done[d] === 1'b1);
                  mf.busy_ok  = m_busy[d] && (busy[d] === 1'b0);
                  mf.gap      = m_start[d] - prev_stop[d];
                  prev_stop[d] = m_start[d] + 9 * mn;
                  frm[d].push_back(mf);
                  m_act[d] = 0;
               end
            end
         end
      end
   end

   task automatic push(input int d, input logic [7:0] b);
      fdat[d].push_back(b);
   endtask

   task automatic wait_frames(input int d, input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (frm[d].size() >= n) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset;
      rst = 2'b11; en = 2'b11;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx, busy, rdreq, done} !== 8'b11_00_00_00) begin
         n_fail++; $display("FAIL reset_outputs: got %b required %b", {tx, busy, rdreq, done}, 8'b11_00_00_00);
      end
      rst = 2'b00;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({tx, busy, rdreq, done} !== 8'b11_00_00_00) begin
         n_fail++; $display("FAIL idle_after_reset: got %b required %b", {tx, busy, rdreq, done}, 8'b11_00_00_00);
      end
   endtask

   task automatic test_empty_idle;
      int bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rdreq[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL empty_idle: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_single;
      int rd0 = rd_cnt[0];
      int dn0 = done_cnt[0];
      bit ok;
      frame_t f;
      @(negedge clk); push(0, 8'hA5);
      wait_frames(0, 1, 200, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got %0d required 1", ok); end
      if (ok) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {8'hA5, 5'b11111}) begin
            n_fail++; $display("FAIL single_frame: got %h/%b%b%b%b%b required a5/11111",
               f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok);
         end
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (rd_cnt[0] - rd0 != 1) begin n_fail++; $display("FAIL single_rdreq_cycles: got %0d required 1", rd_cnt[0] - rd0); end
      n_checks++;
      if (done_cnt[0] - dn0 != 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt[0] - dn0); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [3];
      int rd0 = rd_cnt[0];
      bit ok;
      frame_t f;
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
      @(negedge clk);
      for (int i = 0; i < 3; i++) push(0, exp[i]);
      wait_frames(0, 3, 400, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %0d required 1", ok); end
      for (int i = 0; i < 3 && frm[0].size() > 0; i++) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {exp[i], 5'b11111}) begin
            n_fail++; $display("FAIL b2b_frame%0d: got %h/%b%b%b%b%b required %h/11111", i,
               f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok, exp[i]);
         end
         if (i > 0) begin
            n_checks++;
            if (f.gap != CPB0 + 3) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d required %0d", i, f.gap, CPB0 + 3); end
         end
      end
      repeat (50) @(negedge clk);
      n_checks++;
      if (rd_cnt[0] - rd0 != 3) begin n_fail++; $display("FAIL b2b_reads: got %0d required 3", rd_cnt[0] - rd0); end
      n_checks++;
      if (underflow[0] != 0) begin n_fail++; $display("FAIL b2b_underflow: got %0d required 0", underflow[0]); end
   endtask

   task automatic test_enable_drop;
      int rd0 = rd_cnt[0];
      int bad = 0;
      int k = 0;
      bit ok = 0;
      frame_t f;
      logic [7:0] exp [2];
      exp[0] = 8'h11; exp[1] = 8'h22;
      @(negedge clk); push(0, 8'h3C);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (m_act[0] && m_off[0] >= 3 * CPB0) begin ok = 1; break; end
      end
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL en_reach_data: got %0d required 1", ok); end
      @(negedge clk);
      en[0] = 1'b0; push(0, exp[0]); push(0, exp[1]);
      wait_frames(0, 1, 200, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL en_frame_timeout: got %0d required 1", ok); end
      if (ok) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {8'h3C, 5'b11111}) begin
            n_fail++; $display("FAIL en_frame: got %h/%b%b%b%b%b required 3c/11111",
               f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok);
         end
      end
      repeat (40) begin
         @(negedge clk);
         if (rdreq[0] !== 1'b0 || busy[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0 || rd_cnt[0] - rd0 != 1) begin
         n_fail++; $display("FAIL en_hold: bad=%0d reads=%0d required 0 and 1", bad, rd_cnt[0] - rd0);
      end
      // Enable at a negedge: next edge samples, two more edges and tx falls.
      en[0] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (k == 0 && tx[0] === 1'b0) k = i;
      end
      n_checks++;
      if (k != 3) begin n_fail++; $display("FAIL en_restart_edges: got %0d required 3", k); end
      wait_frames(0, 2, 300, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL en_resume_timeout: got %0d required 1", ok); end
      for (int i = 0; i < 2 && frm[0].size() > 0; i++) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {exp[i], 5'b11111}) begin
            n_fail++; $display("FAIL en_resume_frame%0d: got %h required %h", i, f.data, exp[i]);
         end
      end
   endtask

   task automatic test_reset_midframe;
      int rd0 = rd_cnt[0];
      bit ok = 0;
      frame_t f;
      @(negedge clk); push(0, 8'h81);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (m_act[0] && m_off[0] > 5 * CPB0 && m_off[0] < 6 * CPB0) begin ok = 1; break; end
      end
      n_checks++;
      if (ok !== 1'b1 || tx[0] !== 1'b0) begin
         n_fail++; $display("FAIL rst_reach_bit4: reached=%0d tx=%b required 1 and 0", ok, tx[0]);
      end
      #1 rst[0] = 1'b1;
      #1;
      n_checks++;
      if ({tx[0], busy[0]} !== 2'b10) begin
         n_fail++; $display("FAIL rst_async: got tx/busy=%b required 10", {tx[0], busy[0]});
      end
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (frm[0].size() != 0 || rd_cnt[0] - rd0 != 1) begin
         n_fail++; $display("FAIL rst_discard: frames=%0d reads=%0d required 0 and 1", frm[0].size(), rd_cnt[0] - rd0);
      end
      push(0, 8'h5A);
      wait_frames(0, 1, 200, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_next_timeout: got %0d required 1", ok); end
      if (ok) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {8'h5A, 5'b11111}) begin
            n_fail++; $display("FAIL rst_next_frame: got %h required 5a", f.data);
         end
      end
      n_checks++;
      if (rd_cnt[0] - rd0 != 2) begin n_fail++; $display("FAIL rst_reads: got %0d required 2", rd_cnt[0] - rd0); end
   endtask

   task automatic test_random;
      logic [7:0] exp [$];
      logic [7:0] b;
      bit ok;
      frame_t f;
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 30)) @(negedge clk);
         if (i == 0) @(negedge clk);
         b = 8'($urandom);
         exp.push_back(b); push(0, b);
      end
      wait_frames(0, 6, 600, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_timeout: got %0d required 1", ok); end
      for (int i = 0; i < 6 && frm[0].size() > 0; i++) begin
         f = frm[0].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {exp[i], 5'b11111}) begin
            n_fail++; $display("FAIL rand_frame%0d: got %h required %h", i, f.data, exp[i]);
         end
      end
   endtask

   task automatic test_stream;
      logic [7:0] exp [$];
      logic [7:0] b;
      int rd0 = rd_cnt[1];
      bit ok;
      frame_t f;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         exp.push_back(b); push(1, b);
      end
      wait_frames(1, 16, 16 * (10 * CPB1 + 5) + 100, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL stream_timeout: got %0d required 1", ok); end
      for (int i = 0; i < 16 && frm[1].size() > 0; i++) begin
         f = frm[1].pop_front();
         n_checks++;
         if ({f.data, f.start_ok, f.stop_ok, f.uniform, f.done_ok, f.busy_ok} !== {exp[i], 5'b11111}) begin
            n_fail++; $display("FAIL stream_frame%0d: got %h required %h", i, f.data, exp[i]);
         end
         if (i > 0) begin
            n_checks++;
            if (f.gap != CPB1 + 3) begin n_fail++; $display("FAIL stream_gap%0d: got %0d required %0d", i, f.gap, CPB1 + 3); end
         end
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (rd_cnt[1] - rd0 != 16 || underflow[1] != 0) begin
         n_fail++; $display("FAIL stream_reads: reads=%0d underflow=%0d required 16 and 0", rd_cnt[1] - rd0, underflow[1]);
      end
   endtask

   initial begin
      test_reset();
      test_empty_idle();
      test_single();
      test_back_to_back();
      test_enable_drop();
      test_reset_midframe();
      test_random();
      test_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
